// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer uplink arbiter.
// State encodings, source ids and stream width helpers.
package la_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_GNT_UP = 2'b01,
        ARB_GNT_LA = 2'b10,
        ARB_BAD    = 2'b11
    } arb_state_t;

    localparam logic SRC_UP = 1'b0;
    localparam logic SRC_LA = 1'b1;

    function automatic int keep_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage forward register slice for AXI-Stream with a source tag.
// Loads on every accepted beat, drains when the sink takes it.
module axis_reg_slice
    import la_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pUSER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_tvalid,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic [pDATA_WIDTH/8-1:0] s_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] s_tkeep,
    input  logic [pUSER_WIDTH-1:0]   s_tuser,
    input  logic                     s_tlast,
    input  logic                     s_tsrc,
    output logic                     slice_ready,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic [pDATA_WIDTH/8-1:0] m_tstrb,
    output logic [pDATA_WIDTH/8-1:0] m_tkeep,
    output logic [pUSER_WIDTH-1:0]   m_tuser,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    output logic                     m_tsrc,
    input  logic                     m_tready
);

    assign slice_ready = !m_tvalid || m_tready;

    // Capture an accepted beat, otherwise retire the held one once taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tstrb  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= '0;
            m_tlast  <= 1'b0;
            m_tsrc   <= SRC_UP;
        end else if (s_tvalid) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tstrb  <= s_tstrb;
            m_tkeep  <= s_tkeep;
            m_tuser  <= s_tuser;
            m_tlast  <= s_tlast;
            m_tsrc   <= s_tsrc;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/la_axis_arbiter.sv
// Packet-level arbiter sharing the AXIS uplink between user and LA streams.
// Grants last a whole packet; LA high priority is bounded by a starvation guard.
module la_axis_arbiter
    import la_pkg::*;
#(
    parameter int pDATA_WIDTH   = 32,
    parameter int pUSER_WIDTH   = 2,
    parameter int pMAX_HPRI_PKT = 4
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic [pDATA_WIDTH-1:0]   up_tdata,
    input  logic [pDATA_WIDTH/8-1:0] up_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] up_tkeep,
    input  logic [pUSER_WIDTH-1:0]   up_tuser,
    input  logic                     up_tlast,
    input  logic                     up_tvalid,
    output logic                     up_tready,
    input  logic [pDATA_WIDTH-1:0]   la_tdata,
    input  logic [pDATA_WIDTH/8-1:0] la_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] la_tkeep,
    input  logic [pUSER_WIDTH-1:0]   la_tuser,
    input  logic                     la_tlast,
    input  logic                     la_tvalid,
    output logic                     la_tready,
    input  logic                     la_hpri_req,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic [pDATA_WIDTH/8-1:0] m_tstrb,
    output logic [pDATA_WIDTH/8-1:0] m_tkeep,
    output logic [pUSER_WIDTH-1:0]   m_tuser,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    output logic                     m_tsrc,
    input  logic                     m_tready,
    output logic [1:0]               arb_state
);

    localparam int KW = keep_width(pDATA_WIDTH);
    localparam logic [3:0] MAX_CNT = 4'(pMAX_HPRI_PKT);

    arb_state_t state;
    logic       last_src;
    logic [3:0] hpri_cnt;
    logic       slice_ready;
    logic       up_fire;
    logic       la_fire;
    logic       hpri_win;
    logic       grant_up;
    logic       grant_la;

    logic                   s_tvalid;
    logic [pDATA_WIDTH-1:0] s_tdata;
    logic [KW-1:0]          s_tstrb;
    logic [KW-1:0]          s_tkeep;
    logic [pUSER_WIDTH-1:0] s_tuser;
    logic                   s_tlast;
    logic                   s_tsrc;

    assign arb_state = state;

    // Only the granted source sees the slice's space; IDLE blocks both.
    always_comb begin
        up_tready = (state == ARB_GNT_UP) && slice_ready;
        la_tready = (state == ARB_GNT_LA) && slice_ready;
        up_fire   = up_tvalid && up_tready;
        la_fire   = la_tvalid && la_tready;
    end

    // Steer the granted source into the slice.
    always_comb begin
        s_tvalid = up_fire || la_fire;
        if (state == ARB_GNT_LA) begin
            s_tdata = la_tdata;
            s_tstrb = la_tstrb;
            s_tkeep = la_tkeep;
            s_tuser = la_tuser;
            s_tlast = la_tlast;
            s_tsrc  = SRC_LA;
        end else begin
            s_tdata = up_tdata;
            s_tstrb = up_tstrb;
            s_tkeep = up_tkeep;
            s_tuser = up_tuser;
            s_tlast = up_tlast;
            s_tsrc  = SRC_UP;
        end
    end

    // IDLE decision: bounded LA priority, then round-robin, then any valid.
    always_comb begin
        hpri_win = la_tvalid && la_hpri_req &&
                   (!up_tvalid || (hpri_cnt < MAX_CNT));
        grant_up = 1'b0;
        grant_la = 1'b0;
        if (hpri_win) begin
            grant_la = 1'b1;
        end else if (up_tvalid && la_tvalid) begin
            grant_up = (last_src == SRC_LA);
            grant_la = (last_src == SRC_UP);
        end else begin
            grant_up = up_tvalid;
            grant_la = la_tvalid;
        end
    end

    // Grant FSM: hold the grant until the source's tlast beat is accepted.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state    <= ARB_IDLE;
            last_src <= SRC_LA;
            hpri_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_up) begin
                        state    <= ARB_GNT_UP;
                        last_src <= SRC_UP;
                        hpri_cnt <= '0;
                    end else if (grant_la) begin
                        state    <= ARB_GNT_LA;
                        last_src <= SRC_LA;
                        if (hpri_win && up_tvalid && (hpri_cnt < MAX_CNT))
                            hpri_cnt <= hpri_cnt + 4'd1;
                    end
                end
                ARB_GNT_UP: begin
                    if (up_fire && up_tlast)
                        state <= ARB_IDLE;
                end
                ARB_GNT_LA: begin
                    if (la_fire && la_tlast)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    axis_reg_slice #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pUSER_WIDTH (pUSER_WIDTH)
    ) u_slice (
        .clk         (axis_clk),
        .rst_n       (axis_rst_n),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tstrb     (s_tstrb),
        .s_tkeep     (s_tkeep),
        .s_tuser     (s_tuser),
        .s_tlast     (s_tlast),
        .s_tsrc      (s_tsrc),
        .slice_ready (slice_ready),
        .m_tdata     (m_tdata),
        .m_tstrb     (m_tstrb),
        .m_tkeep     (m_tkeep),
        .m_tuser     (m_tuser),
        .m_tlast     (m_tlast),
        .m_tvalid    (m_tvalid),
        .m_tsrc      (m_tsrc),
        .m_tready    (m_tready)
    );

endmodule

// File: doc/la_axis_arbiter.md
# la_axis_arbiter

Packet-level AXI-Stream arbiter that shares the single upstream AXIS uplink between the user-project stream and the logic-analyzer capture stream. Sits between those two masters and the uplink, in the axis_clk domain. Grants are held for a whole packet (through tlast). The logic analyzer's high-priority request (la_hpri_req) preempts round-robin at packet boundaries, with a starvation guard for the user stream. The output is a one-stage registered slice.

## Interface
- pDATA_WIDTH, 32: tdata width; tstrb/tkeep are pDATA_WIDTH/8.
- pUSER_WIDTH, 2: tuser width.
- pMAX_HPRI_PKT, 4: max consecutive hpri LA packets granted while user stream waits; range 1..15.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst_n  in  1  reset; **reset is synchronous and active-low**.
- up_tdata/up_tstrb/up_tkeep/up_tuser/up_tlast/up_tvalid  in  32/4/4/2/1/1  user-project stream.
- up_tready  out  1  ready to user project.
- la_tdata/la_tstrb/la_tkeep/la_tuser/la_tlast/la_tvalid  in  32/4/4/2/1/1  logic-analyzer stream.
- la_tready  out  1  ready to logic analyzer.
- la_hpri_req  in  1  LA FIFO above high threshold; sampled only at arbitration.
- m_tdata/m_tstrb/m_tkeep/m_tuser/m_tlast/m_tvalid  out  32/4/4/2/1/1  uplink stream, registered.
- m_tsrc  out  1  source of the current m_ beat: 0 = up, 1 = la. Registered with the data.
- m_tready  in  1  uplink ready.
- arb_state  out  2  FSM state, for debug.

## Operation
- FSM states: IDLE=2'b00, GNT_UP=2'b01, GNT_LA=2'b10. 2'b11 is illegal and returns to IDLE.
- IDLE decision, evaluated every cycle in IDLE:
  - If la_tvalid && la_hpri_req && (!up_tvalid || hpri_cnt < pMAX_HPRI_PKT) -> GNT_LA.
  - Else if both valid -> grant the source opposite last_src.
  - Else grant whichever is valid.
  - Neither valid -> stay in IDLE.
- hpri_cnt (4 bit):
  - Increments on each hpri-based LA grant taken while up_tvalid=1.
  - Clears on any GNT_UP grant.
  - Saturates at pMAX_HPRI_PKT.
- last_src updates on every grant.
- Register slice: slice_ready = !m_tvalid || m_tready. The granted source's tready = slice_ready; the non-granted source's tready = 0. In IDLE both treadys = 0.
- Beat accepted (src tvalid && tready) -> m_* load source fields next edge, m_tvalid=1, m_tsrc=source.
- Else if m_tready -> m_tvalid=0.
- Grant releases when the beat with tlast=1 is accepted from the source; FSM -> IDLE at that edge. Exactly one IDLE cycle separates packets.
- Zero-length packets do not exist. A single beat with tlast=1 is a 1-beat packet.
- Data, strb, keep, user and last pass unmodified. No beat is dropped, duplicated or reordered.

## Timing
- Reset values: m_tvalid=0, m_tdata/tstrb/tkeep/tuser/tlast=0, m_tsrc=0, up_tready=la_tready=0, arb_state=IDLE, last_src=1 (so the first tie goes to up), hpri_cnt=0.
- Latency: source accept edge -> m_tvalid the next cycle (1 cycle).
- Throughput: 1 beat/cycle within a packet while m_tready=1. Inter-packet bubble: 1 cycle.
- m_* hold stable while m_tvalid && !m_tready (AXIS compliant). tready never depends on the source's own tvalid.
- Grant decision in IDLE is registered: first tready of the packet is at IDLE+1.
- la_hpri_req toggling mid-packet has no effect until the next IDLE.
- Source dropping tvalid mid-packet: grant held, no re-arbitration until tlast.
- Synchronous reset mid-packet: all state clears at the reset edge. The in-flight m_ beat is discarded and the packet is truncated. Source recovery is the sources' responsibility.

## Structure
- Shared package la_pkg: arb state encodings, SRC_UP/SRC_LA constants, tkeep width function.
- One sub-module, axis_reg_slice: pDATA_WIDTH/pUSER_WIDTH forward register with tsrc sideband. The arbiter FSM and mux stay in la_axis_arbiter.

## Test plan
- Reset then up-only 4-beat packet 0x1..0x4, m_tready=1:
  - m_tdata 0x1..0x4 on consecutive cycles starting 2 cycles after up_tvalid.
  - m_tlast on 0x4, m_tsrc=0, la_tready=0 throughout.
- Both valid, la_hpri_req=0, 2-beat packets each:
  - Order: up, la, up, la.
  - One IDLE cycle between packets.
- la_hpri_req=1, both continuously valid, pMAX_HPRI_PKT=4:
  - 4 LA packets, then 1 up packet, then 4 LA packets; hpri_cnt visible.
- m_tready toggled 1/0 randomly during an 8-beat LA packet:
  - All 8 beats arrive in order with no duplicates.
  - m_* stable while stalled.
- Reset asserted on beat 3 of a 6-beat up packet:
  - Next cycle m_tvalid=0, both treadys=0, arb_state=IDLE.
  - A new la packet is then granted normally.
- la_hpri_req raised mid up packet: the up packet completes fully before the LA grant.
